// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the multi-port register file.
//   - default XLEN / NREGS
//   - clog2 helper used to derive the register address width
//   - packed-port slicing helper (port index -> bit offset in a flat bus)
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Smallest r with 2**r >= n; floors at 1 so a 2-entry file still has an address bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // LSB of port idx within a flat bus of w-bit fields.
  function automatic int port_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of reg_file_mp.
//   regs   in   full storage array (entry 0 is held at zero by the top)
//   busy   in   per-register pending-writeback flags
//   we/waddr/wdata in  flat write bus, used for same-cycle forwarding
//   raddr  in   register to read
//   rdata  out  read data (x0 -> 0, else forwarded or stored value)
//   rbusy  out  busy flag of raddr, masked when the value is being forwarded
module rf_read_port import rf_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [NREGS-1:0]           busy,
  input  logic [NWR-1:0]             we,
  input  logic [NWR*AW-1:0]          waddr,
  input  logic [NWR*XLEN-1:0]        wdata,
  input  logic [AW-1:0]              raddr,
  output logic [XLEN-1:0]            rdata,
  output logic                       rbusy
);

  logic            hit;
  logic [XLEN-1:0] fwd;

  // Scan ports low to high so the highest-index matching writer wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && (waddr[port_lsb(k, AW) +: AW] == raddr)) begin
        hit = 1'b1;
        fwd = wdata[port_lsb(k, XLEN) +: XLEN];
      end
    end
  end

  always_comb begin
    rdata = regs[raddr];
    rbusy = busy[raddr];
    if (raddr == '0) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if ((BYPASS != 0) && hit) begin
      // The forwarded value is the one the consumer is waiting for.
      rdata = fwd;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port integer register file with busy scoreboard.
//   clk, rst_n   clock, asynchronous active-low reset (clears regs and busy)
//   we[NWR]      write enables; waddr/wdata flat buses, port k at [k*AW], [k*XLEN]
//   raddr[NRD*AW] read addresses; rdata[NRD*XLEN], rbusy[NRD] combinational results
//   iss_valid/iss_addr  mark a register busy (producer issued)
// x0 reads as zero, ignores writes and is never busy. Highest-index write port
// wins on a same-address conflict; an issue beats a retiring write on busy.
module reg_file_mp import rf_pkg::*; #(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  parameter  int BYPASS = 1,
  localparam int AW     = clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr
);

  logic [NREGS-1:0][XLEN-1:0] regs, regs_nxt;
  logic [NREGS-1:0]           busy, busy_nxt;

  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    // Later ports overwrite earlier ones: highest index wins.
    for (int k = 0; k < NWR; k++) begin
      if (we[k]) begin
        regs_nxt[waddr[port_lsb(k, AW) +: AW]] = wdata[port_lsb(k, XLEN) +: XLEN];
        busy_nxt[waddr[port_lsb(k, AW) +: AW]] = 1'b0;
      end
    end
    // Applied after the clears so a new producer supersedes the retiring one.
    if (iss_valid) busy_nxt[iss_addr] = 1'b1;
    regs_nxt[0] = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      regs <= regs_nxt;
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .BYPASS(BYPASS), .AW(AW)
    ) u_rd (
      .regs  (regs),
      .busy  (busy),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr[i*AW +: AW]),
      .rdata (rdata[i*XLEN +: XLEN]),
      .rbusy (rbusy[i])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (A: 32x32, 2R/2W, bypass; B: 16x64, 4R/2W,
// no bypass). Expected read results are pushed to a scoreboard queue when each
// cycle is driven and popped against the DUT outputs before the clock edge.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   a_we;     logic [9:0]   a_waddr;  logic [63:0]  a_wdata;
  logic [9:0]   a_raddr;  logic [63:0]  a_rdata;  logic [1:0]   a_rbusy;
  logic         a_iss_valid;              logic [4:0]   a_iss_addr;
  logic [1:0]   b_we;     logic [7:0]   b_waddr;  logic [127:0] b_wdata;
  logic [15:0]  b_raddr;  logic [255:0] b_rdata;  logic [3:0]   b_rbusy;
  logic         b_iss_valid;              logic [3:0]   b_iss_addr;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .iss_valid(a_iss_valid), .iss_addr(a_iss_addr));

  reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(2), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .iss_valid(b_iss_valid), .iss_addr(b_iss_addr));

  typedef struct { string tag; logic [63:0] v; } sb_t;
  sb_t sbq[$];

  logic [63:0] m  [2][32];
  bit          mb [2][32];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) begin
        m[d][r]  = '0;
        mb[d][r] = 1'b0;
      end
  endtask

  // One cycle on DUT d: drive at negedge, score reads, update model, wait for posedge.
  task automatic cyc(input string nm, input int d, input logic [1:0] we,
                     input int wa0, input logic [63:0] wd0,
                     input int wa1, input logic [63:0] wd1,
                     input bit iv, input int ia,
                     input int r0, input int r1, input int r2, input int r3);
    int ra[4];
    int wa[2];
    logic [63:0] wd[2];
    logic [63:0] msk, e, got;
    bit eb;
    sb_t x;
    ra  = '{r0, r1, r2, r3};
    wa  = '{wa0, wa1};
    msk = (d != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    wd  = '{wd0 & msk, wd1 & msk};
    @(negedge clk);
    a_we = '0; a_iss_valid = 1'b0; b_we = '0; b_iss_valid = 1'b0;
    if (d == 0) begin
      a_we = we; a_waddr = {5'(wa[1]), 5'(wa[0])};
      a_wdata = {wd[1][31:0], wd[0][31:0]};
      a_iss_valid = iv; a_iss_addr = 5'(ia);
      a_raddr = {5'(ra[1]), 5'(ra[0])};
    end else begin
      b_we = we; b_waddr = {4'(wa[1]), 4'(wa[0])};
      b_wdata = {wd[1], wd[0]};
      b_iss_valid = iv; b_iss_addr = 4'(ia);
      b_raddr = {4'(ra[3]), 4'(ra[2]), 4'(ra[1]), 4'(ra[0])};
    end
    for (int p = 0; p < ((d != 0) ? 4 : 2); p++) begin
      e  = m[d][ra[p]];
      eb = mb[d][ra[p]];
      if (d == 0)
        for (int k = 0; k < 2; k++)
          if (we[k] && wa[k] == ra[p]) begin e = wd[k]; eb = 1'b0; end
      if (ra[p] == 0) begin e = '0; eb = 1'b0; end
      x.tag = $sformatf("%s.d%0d.rdata%0d", nm, d, p); x.v = e;
      sbq.push_back(x);
      x.tag = $sformatf("%s.d%0d.rbusy%0d", nm, d, p); x.v = {63'd0, eb};
      sbq.push_back(x);
    end
    #2;
    for (int p = 0; p < ((d != 0) ? 4 : 2); p++) begin
      got = (d != 0) ? b_rdata[p*64 +: 64] : {32'd0, a_rdata[p*32 +: 32]};
      x = sbq.pop_front();
      chk(x.tag, got, x.v);
      got = {63'd0, (d != 0) ? b_rbusy[p] : a_rbusy[p]};
      x = sbq.pop_front();
      chk(x.tag, got, x.v);
    end
    if (rst_n) begin
      for (int k = 0; k < 2; k++)
        if (we[k] && wa[k] != 0) begin m[d][wa[k]] = wd[k]; mb[d][wa[k]] = 1'b0; end
      if (iv && ia != 0) mb[d][ia] = 1'b1;
    end
    @(posedge clk);
  endtask

  initial begin
    int nr, wa0, wa1, ia, ra[4];
    a_we = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0; a_iss_valid = 1'b0; a_iss_addr = '0;
    b_we = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0; b_iss_valid = 1'b0; b_iss_addr = '0;
    model_clear();

    // Reset state
    cyc("rst", 0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc("rst", 1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 1, 15);
    #2 rst_n = 1'b1;

    // Async reset clears a written register mid-cycle
    cyc("wr5", 0, 2'b01, 5, 64'hDEADBEEF, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc("rd5", 0, 2'b00, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0);
    #2 chk("pre_rst.x5", {32'd0, a_rdata[31:0]}, 64'hDEADBEEF);
    chk("pre_rst.busy5", {63'd0, a_rbusy[0]}, 64'd1);
    rst_n = 1'b0;
    #1 chk("async_rst.x5", {32'd0, a_rdata[31:0]}, 64'd0);
    chk("async_rst.busy5", {63'd0, a_rbusy[0]}, 64'd0);
    model_clear();
    // Writes and issues during reset are ignored; bypass still forwards
    cyc("rst_wr", 0, 2'b01, 6, 64'hCAFE, 0, 0, 1, 6, 6, 0, 0, 0);
    #2 rst_n = 1'b1;
    cyc("post_rst", 0, 2'b00, 0, 0, 0, 0, 0, 0, 6, 5, 0, 0);

    // x0 is hardwired
    cyc("x0wr", 0, 2'b11, 0, 64'h1234, 0, 64'h1234, 1, 0, 0, 0, 0, 0);
    cyc("x0rd", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic write/read with bypass
    cyc("x7", 0, 2'b01, 7, 64'hA5A5A5A5, 0, 0, 0, 0, 7, 7, 0, 0);
    cyc("x7n", 0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);

    // Write conflict: port 1 wins
    cyc("cfl", 0, 2'b11, 3, 64'h11, 3, 64'h22, 0, 0, 3, 3, 0, 0);
    cyc("cfln", 0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 7, 0, 0);

    // Scoreboard set/clear with bypass mask
    cyc("iss9", 0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0, 0, 0);
    cyc("busy9", 0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0);
    cyc("idle9", 0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    cyc("wr9", 0, 2'b01, 9, 64'h55, 0, 0, 0, 0, 9, 9, 0, 0);
    cyc("wr9n", 0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);

    // Set/clear collision: set wins
    cyc("col4", 0, 2'b10, 0, 0, 4, 64'h77, 1, 4, 4, 0, 0, 0);
    cyc("col4n", 0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 0, 0);

    // Instance B: no bypass
    cyc("bx7", 1, 2'b01, 7, 64'hA5A5A5A5_5A5A5A5A, 0, 0, 0, 0, 7, 7, 0, 3);
    cyc("bx7n", 1, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 7, 3);
    cyc("biss9", 1, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0, 0, 0);
    cyc("bbusy9", 1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0);
    cyc("bidle9", 1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    cyc("bwr9", 1, 2'b01, 9, 64'h55, 0, 0, 0, 0, 9, 9, 0, 0);
    cyc("bwr9n", 1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 9, 0);
    cyc("bcol4", 1, 2'b01, 4, 64'h77, 0, 0, 1, 4, 4, 0, 0, 0);
    cyc("bcol4n", 1, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 4, 4);
    cyc("bcfl", 1, 2'b11, 3, 64'h11, 3, 64'h22, 0, 0, 3, 3, 3, 3);
    cyc("bcfln", 1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0);

    // Sweep: distinct 64-bit patterns, four concurrent reads with wrap at 15
    for (int i = 1; i < 16; i++)
      cyc("bsw_w", 1, 2'b01, i, {32'h0123_0000 | 32'(i), ~(32'h0F00_0000 | 32'(i*3))},
          0, 0, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 16; b++)
      cyc("bsw_r", 1, 2'b00, 0, 0, 0, 0, 0, 0, b, (b+1) % 16, (b+2) % 16, (b+3) % 16);

    // Random traffic on both instances, small address range half the time
    for (int n = 0; n < 300; n++) begin
      int d;
      d  = n % 2;
      nr = ((n / 2) % 2 != 0) ? 8 : ((d != 0) ? 16 : 32);
      wa0 = $urandom_range(0, nr-1); wa1 = $urandom_range(0, nr-1);
      ia  = $urandom_range(0, nr-1);
      for (int p = 0; p < 4; p++) ra[p] = $urandom_range(0, nr-1);
      cyc("rnd", d, 2'($urandom), wa0, {$urandom, $urandom}, wa1, {$urandom, $urandom},
          1'($urandom), ia, ra[0], ra[1], ra[2], ra[3]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
